// File: rtl/lif_pkg.sv
// Shared types and constants for the leaky integrate-and-fire neuron.
// Width helpers keep the core and its bench consistent.
package lif_pkg;

    typedef enum logic {
        INTEG  = 1'b0,
        REFRAC = 1'b1
    } lif_state_e;

    localparam int LEAK_W = 3;

    function automatic int lif_sum_w(input int n_stage);
        return n_stage + 2;
    endfunction

    function automatic bit lif_width_ok(input int mem_w, input int sum_w);
        return mem_w >= sum_w;
    endfunction

endpackage

// File: rtl/lif_refractory_counter.sv
// Refractory down-counter: loads a period, steps down once per valid
// timestep, and flags the last refractory timestep.
module lif_refractory_counter #(
    parameter int REF_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [REF_W-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [REF_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == REF_W'(1));

endmodule

// File: rtl/lif_neuron_core.sv
// Leaky integrate-and-fire membrane stage with saturating accumulate,
// shift-based leak, one-cycle spike and programmable refractory period.
module lif_neuron_core
    import lif_pkg::*;
#(
    parameter  int N_STAGE = 5,
    parameter  int MEM_W   = 8,
    parameter  int REF_W   = 4,
    localparam int SUM_W   = lif_sum_w(N_STAGE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SUM_W-1:0]  sum_in,
    input  logic              sum_valid,
    input  logic [MEM_W-1:0]  threshold,
    input  logic [LEAK_W-1:0] leak_shift,
    input  logic [REF_W-1:0]  refrac_period,
    output logic              spike,
    output logic [MEM_W-1:0]  membrane,
    output logic              refractory
);

    if (!lif_width_ok(MEM_W, SUM_W)) begin : g_width_check
        $error("lif_neuron_core: MEM_W must be >= SUM_W");
    end

    lif_state_e       state_q, state_d;
    logic [MEM_W-1:0] mem_d;
    logic             spike_d;
    logic             load;
    logic             done;

    logic [MEM_W-1:0] leaked;
    logic [MEM_W:0]   acc;
    logic [MEM_W-1:0] nxt;
    logic             fire;

    // Sum is zero-extended; the extra bit of acc catches overflow.
    assign leaked = (leak_shift == '0) ? membrane
                                       : membrane - (membrane >> leak_shift);
    assign acc    = {1'b0, leaked}
                  + {{(MEM_W + 1 - SUM_W){1'b0}}, sum_in};
    assign nxt    = acc[MEM_W] ? {MEM_W{1'b1}} : acc[MEM_W-1:0];
    assign fire   = (threshold != '0) && (nxt >= threshold);

    lif_refractory_counter #(
        .REF_W(REF_W)
    ) u_refrac (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .load_val(refrac_period),
        .dec     (sum_valid && state_q == REFRAC),
        .done    (done)
    );

    always_comb begin
        state_d = state_q;
        mem_d   = membrane;
        spike_d = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            INTEG: begin
                if (sum_valid) begin
                    if (fire) begin
                        spike_d = 1'b1;
                        mem_d   = '0;
                        if (refrac_period != '0) begin
                            state_d = REFRAC;
                            load    = 1'b1;
                        end
                    end else begin
                        mem_d = nxt;
                    end
                end
            end
            REFRAC: begin
                if (sum_valid) begin
                    mem_d = '0;
                    if (done) begin
                        state_d = INTEG;
                    end
                end
            end
            default: state_d = INTEG;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= INTEG;
            membrane <= '0;
            spike    <= 1'b0;
        end else begin
            state_q  <= state_d;
            membrane <= mem_d;
            spike    <= spike_d;
        end
    end

    assign refractory = (state_q == REFRAC);

endmodule

// File: tb/tb_lif_neuron_core.sv
// Directed bench for lif_neuron_core with hand-computed expectations.
module tb_lif_neuron_core;

    logic       clk;
    logic       rst_n;
    logic [6:0] sum_in;
    logic       sum_valid;
    logic [7:0] threshold;
    logic [2:0] leak_shift;
    logic [3:0] refrac_period;
    logic       spike;
    logic [7:0] membrane;
    logic       refractory;

    int n_assert = 0;
    int n_fail   = 0;

    lif_neuron_core #(
        .N_STAGE(5),
        .MEM_W  (8),
        .REF_W  (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sum_in       (sum_in),
        .sum_valid    (sum_valid),
        .threshold    (threshold),
        .leak_shift   (leak_shift),
        .refrac_period(refrac_period),
        .spike        (spike),
        .membrane     (membrane),
        .refractory   (refractory)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] m,
                           input logic s, input logic r);
        chk({tag, ".membrane"}, {24'b0, membrane}, {24'b0, m});
        chk({tag, ".spike"}, {31'b0, spike}, {31'b0, s});
        chk({tag, ".refractory"}, {31'b0, refractory}, {31'b0, r});
    endtask

    task automatic step(input logic v, input logic [6:0] s);
        sum_valid = v;
        sum_in    = s;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        sum_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b0;
        sum_in        = 7'd64;
        sum_valid     = 1'b1;
        threshold     = 8'd100;
        leak_shift    = 3'd0;
        refrac_period = 4'd2;

        // 1: reset holds everything clear despite valid input
        #2;
        chk_out("rst_async", 8'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk_out("rst_c1", 8'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk_out("rst_c2", 8'd0, 1'b0, 1'b0);
        sum_valid = 1'b0;
        rst_n     = 1'b1;

        // 2: integrate, fire, refractory of 2
        step(1'b1, 7'd30); chk_out("int1", 8'd30, 1'b0, 1'b0);
        step(1'b1, 7'd30); chk_out("int2", 8'd60, 1'b0, 1'b0);
        step(1'b1, 7'd30); chk_out("int3", 8'd90, 1'b0, 1'b0);
        step(1'b1, 7'd30); chk_out("fire", 8'd0, 1'b1, 1'b1);
        step(1'b1, 7'd30); chk_out("ref1", 8'd0, 1'b0, 1'b1);
        step(1'b1, 7'd30); chk_out("ref2", 8'd0, 1'b0, 1'b0);
        step(1'b1, 7'd30); chk_out("post", 8'd30, 1'b0, 1'b0);

        // 3: leak with shift 2
        do_reset();
        threshold  = 8'd0;
        leak_shift = 3'd2;
        step(1'b1, 7'd64); chk_out("leak1", 8'd64, 1'b0, 1'b0);
        step(1'b1, 7'd64); chk_out("leak2", 8'd112, 1'b0, 1'b0);
        step(1'b1, 7'd64); chk_out("leak3", 8'd148, 1'b0, 1'b0);
        step(1'b1, 7'd64); chk_out("leak4", 8'd175, 1'b0, 1'b0);
        step(1'b0, 7'd64); chk_out("leak_hold", 8'd175, 1'b0, 1'b0);

        // 4: saturation, no leak, firing disabled
        do_reset();
        leak_shift = 3'd0;
        step(1'b1, 7'd64); chk_out("sat1", 8'd64, 1'b0, 1'b0);
        step(1'b1, 7'd64); chk_out("sat2", 8'd128, 1'b0, 1'b0);
        step(1'b1, 7'd64); chk_out("sat3", 8'd192, 1'b0, 1'b0);
        step(1'b1, 7'd64); chk_out("sat4", 8'd255, 1'b0, 1'b0);
        step(1'b1, 7'd64); chk_out("sat5", 8'd255, 1'b0, 1'b0);

        // threshold equality fires; back-to-back fires with no refractory
        do_reset();
        threshold     = 8'd60;
        refrac_period = 4'd0;
        step(1'b1, 7'd30); chk_out("eq1", 8'd30, 1'b0, 1'b0);
        step(1'b1, 7'd30); chk_out("eq_fire", 8'd0, 1'b1, 1'b0);
        step(1'b1, 7'd60); chk_out("b2b_fire", 8'd0, 1'b1, 1'b0);
        step(1'b0, 7'd60); chk_out("b2b_idle", 8'd0, 1'b0, 1'b0);

        // 5: valid gaps inside a 3-timestep refractory
        do_reset();
        threshold     = 8'd10;
        refrac_period = 4'd3;
        step(1'b1, 7'd20); chk_out("gap_fire", 8'd0, 1'b1, 1'b1);
        refrac_period = 4'd9;
        step(1'b1, 7'd20); chk_out("gap_v1", 8'd0, 1'b0, 1'b1);
        step(1'b0, 7'd20); chk_out("gap_i1", 8'd0, 1'b0, 1'b1);
        step(1'b1, 7'd20); chk_out("gap_v2", 8'd0, 1'b0, 1'b1);
        step(1'b0, 7'd20); chk_out("gap_i2", 8'd0, 1'b0, 1'b1);
        step(1'b1, 7'd20); chk_out("gap_v3", 8'd0, 1'b0, 1'b0);
        step(1'b0, 7'd20); chk_out("gap_i3", 8'd0, 1'b0, 1'b0);

        // 6: async reset mid-refractory
        do_reset();
        refrac_period = 4'd3;
        step(1'b1, 7'd20); chk_out("ar_fire", 8'd0, 1'b1, 1'b1);
        step(1'b1, 7'd20); chk_out("ar_ref", 8'd0, 1'b0, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_out("ar_clear", 8'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        threshold = 8'd50;
        step(1'b1, 7'd40); chk_out("ar_after", 8'd40, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
